// File: rtl/apb_timer_slave.sv
// APB-mapped 8-bit up/down timer with prescaler and W1C status flags.
// Define TIMER_WAIT_STATE_EN to insert one APB wait state per access.
module apb_timer_slave (
  input  logic       pclk,
  input  logic       preset,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       ovf_int,
  output logic       udf_int
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_ready;
  logic        w_setup;
  logic        w_acc;
  logic        w_bad;
  logic        w_wr;
  logic [1:0]  w_w1c;
  logic [7:0]  w_rd;

  logic [7:0]  r_tdr;
  logic [7:0]  r_tcr;
  logic [1:0]  r_tsr;
  logic [7:0]  r_tcnt;
  logic [3:0]  r_div;
  logic        r_clk_d;

  logic        w_clk_cnt;
  logic        w_tick;
  logic        w_load;
  logic        w_en;
  logic        w_dn;
  logic        w_cnt_ev;
  logic        w_set_ovf;
  logic        w_set_udf;

  assign w_setup = psel & ~penable;
  assign w_acc   = psel & penable;

  always_ff @(posedge pclk) begin
    if (preset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // An ACCESS phase is honoured only when it follows a SETUP phase
  always_comb begin
    w_state_nxt = S_IDLE;
    w_ready     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_setup) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        if (w_acc) begin
`ifdef TIMER_WAIT_STATE_EN
          w_state_nxt = S_WAIT;
`else
          w_ready = 1'b1;
`endif
        end else if (w_setup) begin
          w_state_nxt = S_SETUP;
        end
      end
      S_WAIT: begin
        if (w_acc)        w_ready     = 1'b1;
        else if (w_setup) w_state_nxt = S_SETUP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pready  = w_ready & ~preset;
  assign w_bad   = (paddr > 8'h03) | (pwrite & (paddr == 8'h03));
  assign pslverr = pready & w_bad;
  assign w_wr    = pready & pwrite & ~w_bad;
  assign w_w1c   = (w_wr && paddr == 8'h02) ? pwdata[1:0] : 2'b00;

  always_comb begin
    w_rd = 8'h00;
    case (paddr)
      8'h00:   w_rd = r_tdr;
      8'h01:   w_rd = r_tcr;
      8'h02:   w_rd = {6'd0, r_tsr};
      8'h03:   w_rd = r_tcnt;
      default: w_rd = 8'h00;
    endcase
  end

  assign prdata  = pready ? w_rd : 8'h00;
  assign ovf_int = r_tsr[0];
  assign udf_int = r_tsr[1];

  assign w_load    = r_tcr[7];
  assign w_en      = r_tcr[4];
  assign w_dn      = r_tcr[5];
  assign w_clk_cnt = r_div[r_tcr[1:0]];
  assign w_tick    = w_clk_cnt & ~r_clk_d;
  assign w_cnt_ev  = w_tick & w_en & ~w_load;
  assign w_set_ovf = w_cnt_ev & ~w_dn & (r_tcnt == 8'hFF);
  assign w_set_udf = w_cnt_ev & w_dn & (r_tcnt == 8'h00);

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_tdr   <= 8'h00;
      r_tcr   <= 8'h00;
      r_tsr   <= 2'b00;
      r_tcnt  <= 8'h00;
      r_div   <= 4'h0;
      r_clk_d <= 1'b0;
    end else begin
      r_div   <= r_div + 4'd1;
      r_clk_d <= w_clk_cnt;
      if (w_wr && paddr == 8'h00) r_tdr <= pwdata;
      if (w_wr && paddr == 8'h01) r_tcr <= pwdata & 8'hB3;
      // Hardware set takes priority over a same-cycle clear
      r_tsr <= (r_tsr & ~w_w1c) | {w_set_udf, w_set_ovf};
      if (w_load)        r_tcnt <= r_tdr;
      else if (w_cnt_ev) r_tcnt <= w_dn ? r_tcnt - 8'd1 : r_tcnt + 8'd1;
    end
  end

endmodule

// File: doc/apb_timer_slave.md
APB_TIMER_SLAVE -- requirements
Module: apb_timer_slave

Interface
REQ-001 SHALL have port pclk, input, 1, single clock; all logic on rising edge.
REQ-002 SHALL have port preset, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port psel, input, 1, APB select.
REQ-004 SHALL have port penable, input, 1, APB access phase.
REQ-005 SHALL have port pwrite, input, 1, 1 = write, 0 = read.
REQ-006 SHALL have port paddr, input, 8, register address.
REQ-007 SHALL have port pwdata, input, 8, write data.
REQ-008 SHALL have port prdata, output, 8, read data, valid when pready=1.
REQ-009 SHALL have port pready, output, 1, transfer complete.
REQ-010 SHALL have port pslverr, output, 1, error response, valid only when pready=1.
REQ-011 SHALL have port ovf_int, output, 1, equals TSR[0].
REQ-012 SHALL have port udf_int, output, 1, equals TSR[1].

Function
REQ-013 SHALL decode registers as follows:
- 0x00 TDR: RW, load value.
- 0x01 TCR: RW; [1:0] cks, [4] en, [5] dn (1 = count down), [7] load; other bits read 0.
- 0x02 TSR: [0] ovf, [1] udf; write-1-to-clear.
- 0x03 TCNT: read-only.
REQ-014 SHALL implement an APB state machine IDLE -> SETUP (psel=1, penable=0) -> ACCESS (psel=1, penable=1) -> IDLE on pready=1; ACCESS without a prior SETUP SHALL be ignored.
REQ-015 SHALL commit a write only in the ACCESS cycle where pready=1; no register changes in SETUP or wait cycles.
REQ-016 SHALL drive pslverr=1 with pready=1 for paddr>0x03 and for writes to 0x03; no register SHALL change; a read of paddr>0x03 SHALL return prdata=0x00.
REQ-017 SHALL drive prdata=0x00 whenever pready=0.
REQ-018 SHALL run a free-running 4-bit divider div_cnt that increments every pclk.
REQ-019 SHALL generate internal clk_cnt = div_cnt[cks], giving a period of 2/4/8/16 pclk for cks=00/01/10/11.
REQ-020 SHALL generate tick as a one-pclk pulse on each clk_cnt rising edge, detected against a registered copy of clk_cnt.
REQ-021 SHALL apply a new cks from the cycle after the TCR write; div_cnt SHALL NOT reset on a cks change.
REQ-022 SHALL load TCNT from TDR every pclk while load=1; counting and flag setting are suppressed during load.
REQ-023 SHALL update TCNT only on tick while en=1 and load=0: +1 when dn=0, -1 when dn=1.
REQ-024 SHALL wrap 0xFF->0x00 on up count and set ovf; SHALL wrap 0x00->0xFF on down count and set udf.
REQ-025 SHALL keep ovf/udf set until reset or a W1C write; if a hardware set and a W1C hit the same cycle, set SHALL win.
REQ-026 SHALL return the pre-write TCNT value if a TCNT read's pready cycle coincides with a tick.

Reset
REQ-027 SHALL, with preset=1 at a pclk edge, clear TDR, TCR, TSR, TCNT, div_cnt, the clk_cnt copy and the state machine (to IDLE).
REQ-028 SHALL hold prdata=0x00, pready=0, pslverr=0, ovf_int=0 and udf_int=0 during reset and on the cycle after it.
REQ-029 SHALL abandon any transfer in progress when reset is asserted, with no register update.

Configuration
REQ-030 SHALL, with TIMER_WAIT_STATE_EN defined, hold pready=0 in the first ACCESS cycle and drive pready=1 in the second (one wait state).
REQ-031 SHALL, without TIMER_WAIT_STATE_EN, drive pready=1 in the first ACCESS cycle (zero wait states); all other behaviour is identical.

Verification
REQ-032 SHALL cover: for each cks 00/01/10/11, write TCR = cks | 0x10, then measure pclk between consecutive clk_cnt rising edges -> 2/4/8/16 exactly.
REQ-033 SHALL cover: TDR=0xFE, TCR=0x90, then TCR=0x10 (cks=00) -> TCNT 0xFF, 0x00 on successive ticks, ovf_int=1; write TSR=0x01 -> ovf_int=0.
REQ-034 SHALL cover: TDR=0x01, TCR=0xB0, then TCR=0x30 -> TCNT 0x00, 0xFF, udf_int=1, ovf_int stays 0.
REQ-035 SHALL cover: read paddr=0x05 and write paddr=0x03 -> pslverr=1, prdata=0x00, TCNT unchanged.
REQ-036 SHALL cover: W1C TSR=0x01 in the same cycle as an overflow tick -> ovf stays 1.
REQ-037 SHALL cover: preset=1 during a write's ACCESS phase -> write discarded, all registers read 0x00 after reset; pready latency of 1 cycle with TIMER_WAIT_STATE_EN defined, 0 cycles without.
